uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UartTransmitter among N_REQ byte requesters. Round-robin arbitration with packet lock: the winner keeps
//  the transmitter until it sends a byte flagged last. Drives transmitter data/transmitReq and tracks its ready
//  handshake. Enforces an optional inter-frame gap. Sits between on-chip byte sources and the UART TX line.
// PARAMETERS
//  N_REQ         4   number of requesters (2..8)
//  GAP_CYCLES    0   idle clk cycles inserted after each frame completes (0 = none)
//  BUSY_TIMEOUT  16  max cycles to wait for tx_ready to drop after tx_req; on expiry frame is abandoned
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  rst          in   1        asynchronous, active-low reset
//  req_valid    in   N_REQ    requester i has a byte; hold valid/data/last stable until req_ready[i]
//  req_data     in   8*N_REQ  byte of requester i at [8*i+7:8*i]
//  req_last     in   N_REQ    byte ends requester i's packet (releases lock after send)
//  req_ready    out  N_REQ    1-cycle pulse: byte of requester i consumed
//  grant        out  N_REQ    one-hot current owner; all-zero when unowned
//  busy         out  1        state != IDLE or lock held
//  tx_data      out  8        to transmitter data; holds last accepted byte
//  tx_req       out  1        to transmitter transmitReq; 1-cycle pulse
//  tx_ready     in   1        from transmitter ready
//  timeout_err  out  1        1-cycle pulse when BUSY_TIMEOUT expires
// BEHAVIOUR
//  Reset (async, rst=0): all outputs 0, state IDLE, lock clear, rr pointer=0, counters 0.
//  All outputs registered. States: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, GAP.
//  IDLE: needs tx_ready=1 and a candidate. Unlocked: first req_valid[i] scanning ptr, ptr+1, .. mod N_REQ.
//    Locked: only owner eligible; others ignored even if valid. Owner idle while locked: hold grant indefinitely.
//    Select i: latch req_data[i] to tx_data and req_last[i] to last_flag. Set grant one-hot i and lock. Go to ISSUE.
//  ISSUE (1 cycle): tx_req=1 and req_ready[i]=1, same cycle, both exactly 1 cycle. Go to WAIT_LOW, clear counter.
//  WAIT_LOW: tx_ready=0 -> WAIT_HIGH. Else count; at count==BUSY_TIMEOUT pulse timeout_err, treat frame done (-> end).
//  WAIT_HIGH: tx_ready=1 -> end-of-frame. No timeout.
//  End-of-frame: GAP_CYCLES>0 -> GAP for exactly GAP_CYCLES cycles, then IDLE; GAP_CYCLES=0 -> IDLE directly.
//    Release on entry to IDLE if last_flag=1: lock clear, grant=0, ptr=(owner+1) mod N_REQ. Else lock and grant kept.
//  ptr changes only on release (also on timeout release).
//  Timing: tx_ready=1 sampled in WAIT_HIGH at edge E -> next tx_req high in the cycle after edge E+GAP_CYCLES+1.
//  Decision latency: IDLE edge with valid -> tx_req/req_ready high the following cycle.
//  Requesters must update valid/data on the cycle after req_ready. The arbiter never re-samples sooner than 3 cycles later.
//  tx_ready=0 while IDLE (transmitter busy externally): wait, no accept.
//  Simultaneous valids: resolved purely by ptr order. Multi-bit grant is illegal and must never occur.
//  Reset mid-frame: immediate return to reset values. Transmitter state is reset separately. First grant after reset goes to the lowest valid index.
// TESTING
//  1 Single: req0 valid 0x5A last=1 -> one tx_req with tx_data=0x5A, req_ready[0] same cycle. grant=0001 until release, then ptr=1.
//  2 Contention: all 4 valid last=1, data 0x10..0x13 -> tx order 0x10,0x11,0x12,0x13, then 0x10 again if req0 still valid.
//  3 Lock: req1 sends 0xA1,0xA2,0xA3 (last on 0xA3), req2 holds 0xB0 -> order A1,A2,A3,B0. grant stays 0010 across the A-bytes.
//  4 Timeout: tx_ready tied 1 -> timeout_err pulses once, 16 cycles after WAIT_LOW entry. Last_flag=1 releases. No second tx_req for that byte.
//  5 GAP_CYCLES=3 with real UartTransmitter (divisor 10, 8E1): consecutive tx_req spaced frame time+4 cycles after ready rise. Loopback receiver gets bytes intact.
//  6 rst low during WAIT_HIGH -> outputs 0 immediately. After release with req2,req3 valid, first grant=0100.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte-request and transmitter-handshake bundle for uart_tx_arbiter.
// The slave modport is the arbiter; the master modport is the surrounding system.
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_last;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ-1:0]   grant;
   logic               busy;
   logic [7:0]         tx_data;
   logic               tx_req;
   logic               tx_ready;
   logic               timeout_err;

   modport master (
      output req_valid, req_data, req_last, tx_ready,
      input  req_ready, grant, busy, tx_data, tx_req, timeout_err
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_ready,
      output req_ready, grant, busy, tx_data, tx_req, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART transmitter among N_REQ byte
// requesters, with transmitter ready tracking, busy timeout and inter-frame gap.
module uart_tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int GAP_CYCLES   = 0,
   parameter int BUSY_TIMEOUT = 16
) (
   input logic              clk,
   input logic              rst,
   uart_tx_arbiter_if.slave bus
);
   localparam int IDX_W   = $clog2(N_REQ);
   localparam int MAX_CNT = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, GAP} stateType;

   stateType         state, stateNext;
   logic             lock, lockNext;
   logic             lastFlag, lastFlagNext;
   logic [IDX_W-1:0] owner, ownerNext;
   logic [IDX_W-1:0] ptr, ptrNext;
   logic [IDX_W-1:0] candIdx;
   logic             candFound;
   logic [CNT_W-1:0] cnt, cntNext;
   logic [N_REQ-1:0] grantQ, grantNext;
   logic [N_REQ-1:0] reqReadyQ, reqReadyNext;
   logic [7:0]       txDataQ, txDataNext;
   logic             txReqQ, txReqNext;
   logic             busyQ, busyNext;
   logic             timeoutQ, timeoutNext;
   logic             accept, timeoutHit, frameEnd, gapDone;

   // While locked only the owner may win; otherwise the first valid from ptr upward.
   always_comb begin
      candFound = 1'b0;
      candIdx   = owner;
      if (lock) begin
         candFound = bus.req_valid[owner];
      end else begin
         for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(ptr) + k) % N_REQ]) begin
               candFound = 1'b1;
               candIdx   = IDX_W'((int'(ptr) + k) % N_REQ);
            end
         end
      end
   end

   assign accept     = (state == IDLE) && bus.tx_ready && candFound;
   assign timeoutHit = (state == WAIT_LOW) && bus.tx_ready && (int'(cnt) == BUSY_TIMEOUT - 1);
   assign frameEnd   = timeoutHit || ((state == WAIT_HIGH) && bus.tx_ready);
   assign gapDone    = (state == GAP) && (int'(cnt) == GAP_CYCLES - 1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         lock      <= 1'b0;
         lastFlag  <= 1'b0;
         owner     <= '0;
         ptr       <= '0;
         cnt       <= '0;
         grantQ    <= '0;
         reqReadyQ <= '0;
         txDataQ   <= '0;
         txReqQ    <= 1'b0;
         busyQ     <= 1'b0;
         timeoutQ  <= 1'b0;
      end else begin
         state     <= stateNext;
         lock      <= lockNext;
         lastFlag  <= lastFlagNext;
         owner     <= ownerNext;
         ptr       <= ptrNext;
         cnt       <= cntNext;
         grantQ    <= grantNext;
         reqReadyQ <= reqReadyNext;
         txDataQ   <= txDataNext;
         txReqQ    <= txReqNext;
         busyQ     <= busyNext;
         timeoutQ  <= timeoutNext;
      end
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:      if (accept) stateNext = ISSUE;
         ISSUE:     stateNext = WAIT_LOW;
         WAIT_LOW: begin
            if (!bus.tx_ready) stateNext = WAIT_HIGH;
            else if (frameEnd) stateNext = (GAP_CYCLES > 0) ? GAP : IDLE;
         end
         WAIT_HIGH: if (frameEnd) stateNext = (GAP_CYCLES > 0) ? GAP : IDLE;
         GAP:       if (gapDone) stateNext = IDLE;
         default:   stateNext = IDLE;
      endcase
   end

   always_comb begin
      lockNext     = lock;
      lastFlagNext = lastFlag;
      ownerNext    = owner;
      ptrNext      = ptr;
      cntNext      = cnt;
      grantNext    = grantQ;
      txDataNext   = txDataQ;
      txReqNext    = 1'b0;
      reqReadyNext = '0;
      timeoutNext  = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               txDataNext            = bus.req_data[8*int'(candIdx) +: 8];
               lastFlagNext          = bus.req_last[candIdx];
               ownerNext             = candIdx;
               grantNext             = '0;
               grantNext[candIdx]    = 1'b1;
               lockNext              = 1'b1;
               txReqNext             = 1'b1;
               reqReadyNext[candIdx] = 1'b1;
            end
         end
         ISSUE:    cntNext = '0;
         WAIT_LOW: begin
            if (bus.tx_ready) cntNext = cnt + CNT_W'(1);
            if (timeoutHit) begin
               timeoutNext = 1'b1;
               cntNext     = '0;
            end
         end
         WAIT_HIGH: cntNext = '0;
         GAP:       cntNext = cnt + CNT_W'(1);
         default:   cntNext = '0;
      endcase
      // A packet's last byte frees the transmitter as the arbiter re-enters IDLE.
      if ((stateNext == IDLE) && (state != IDLE) && lastFlag) begin
         lockNext  = 1'b0;
         grantNext = '0;
         ptrNext   = (int'(owner) == N_REQ - 1) ? '0 : owner + IDX_W'(1);
      end
      busyNext = (stateNext != IDLE) || lockNext;
   end

   assign bus.grant       = grantQ;
   assign bus.req_ready   = reqReadyQ;
   assign bus.tx_data     = txDataQ;
   assign bus.tx_req      = txReqQ;
   assign bus.busy        = busyQ;
   assign bus.timeout_err = timeoutQ;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scripted byte requesters and a transmitter model,
// with a scoreboard of bytes in the order the arbiter must send them.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
   localparam int N     = 4;
   localparam int GAP   = 3;
   localparam int TMO   = 16;
   localparam int FRAME = 6;

   typedef struct {
      int         idx;
      logic [7:0] data;
   } expT;

   logic clk = 1'b0;
   logic rst = 1'b0;

   uart_tx_arbiter_if #(.N_REQ(N)) tbIf ();

   uart_tx_arbiter #(
      .N_REQ(N), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(tbIf)
   );

   always #5 clk = ~clk;

   int   nChecks  = 0;
   int   nFails   = 0;
   int   cyc      = 0;
   int   lastRise = 0;
   logic prevReady = 1'b0;
   expT  expQ[$];

   logic [7:0] srcData [N][16];
   logic       srcLast [N][16];
   int         srcLen  [N] = '{default: 0};
   int         srcPos  [N] = '{default: 0};

   logic modelOn    = 1'b0;
   logic forceReady = 1'b1;
   int   frameCnt   = 0;

   always_comb begin
      tbIf.req_valid = '0;
      tbIf.req_data  = '0;
      tbIf.req_last  = '0;
      for (int i = 0; i < N; i++) begin
         tbIf.req_valid[i]        = srcPos[i] < srcLen[i];
         tbIf.req_data[8*i +: 8]  = srcData[i][srcPos[i] % 16];
         tbIf.req_last[i]         = srcLast[i][srcPos[i] % 16];
      end
   end

   // Requesters advance after req_ready; transmitter drops ready for a frame after tx_req.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < N; i++)
         if (tbIf.req_ready[i] === 1'b1) srcPos[i] <= srcPos[i] + 1;
      if (!modelOn) begin
         tbIf.tx_ready <= forceReady;
         frameCnt      <= 0;
      end else if (tbIf.tx_req === 1'b1) begin
         tbIf.tx_ready <= 1'b0;
         frameCnt      <= FRAME;
      end else if (frameCnt > 0) begin
         frameCnt <= frameCnt - 1;
      end else begin
         tbIf.tx_ready <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (tbIf.tx_ready === 1'b1 && prevReady !== 1'b1) lastRise <= cyc;
      prevReady <= tbIf.tx_ready;
   end

   task automatic loadByte(input int idx, input logic [7:0] d, input logic l);
      srcData[idx][srcLen[idx]] = d;
      srcLast[idx][srcLen[idx]] = l;
      srcLen[idx] = srcLen[idx] + 1;
   endtask

   task automatic expectByte(input int idx, input logic [7:0] d);
      expT e;
      e.idx  = idx;
      e.data = d;
      expQ.push_back(e);
   endtask

   task automatic waitTxReq(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (tbIf.tx_req === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic waitIdle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (tbIf.busy === 1'b0) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; modelOn = 1'b0; forceReady = 1'b1;
      repeat (3) @(negedge clk);
      nChecks++;
      if ({tbIf.grant, tbIf.req_ready, tbIf.busy, tbIf.tx_data, tbIf.tx_req, tbIf.timeout_err} !== '0) begin
         nFails++;
         $display("FAIL reset_outputs: grant=%b req_ready=%b busy=%b tx_data=%h tx_req=%b timeout_err=%b, required all 0",
                  tbIf.grant, tbIf.req_ready, tbIf.busy, tbIf.tx_data, tbIf.tx_req, tbIf.timeout_err);
      end
      rst = 1'b1; modelOn = 1'b1;
      repeat (3) @(negedge clk);
      nChecks++;
      if (tbIf.busy !== 1'b0 || tbIf.grant !== '0 || tbIf.tx_req !== 1'b0) begin
         nFails++;
         $display("FAIL idle_after_reset: busy=%b grant=%b tx_req=%b, required 0", tbIf.busy, tbIf.grant, tbIf.tx_req);
      end
   endtask

   task automatic test_single();
      bit ok; expT e; logic [N-1:0] oh;
      loadByte(0, 8'h5A, 1'b1);
      expectByte(0, 8'h5A);
      waitTxReq(ok);
      nChecks++;
      if (!ok || expQ.size() == 0) begin
         nFails++; $display("FAIL single_frame: tx_req=0 after 200 cycles, required a pulse");
      end else begin
         e = expQ.pop_front(); oh = '0; oh[e.idx] = 1'b1;
         if (tbIf.tx_data !== e.data || tbIf.req_ready !== oh || tbIf.grant !== oh) begin
            nFails++;
            $display("FAIL single_frame: tx_data=%h req_ready=%b grant=%b, required %h %b %b",
                     tbIf.tx_data, tbIf.req_ready, tbIf.grant, e.data, oh, oh);
         end
      end
      @(negedge clk);
      nChecks++;
      if (tbIf.tx_req !== 1'b0 || tbIf.req_ready !== '0 || tbIf.grant !== 4'b0001) begin
         nFails++;
         $display("FAIL single_pulse: tx_req=%b req_ready=%b grant=%b, required 0 0000 0001",
                  tbIf.tx_req, tbIf.req_ready, tbIf.grant);
      end
      waitIdle(ok);
      nChecks++;
      if (!ok || tbIf.grant !== '0 || tbIf.tx_data !== 8'h5A) begin
         nFails++;
         $display("FAIL single_release: busy=%b grant=%b tx_data=%h, required 0 0000 5a",
                  tbIf.busy, tbIf.grant, tbIf.tx_data);
      end
   endtask

   task automatic test_contention();
      bit ok; expT e; logic [N-1:0] oh;
      // Pointer sits at 1 after requester 0's packet, so 0x10 comes around last.
      loadByte(0, 8'h10, 1'b1); loadByte(0, 8'h20, 1'b1);
      loadByte(1, 8'h11, 1'b1); loadByte(2, 8'h12, 1'b1); loadByte(3, 8'h13, 1'b1);
      expectByte(1, 8'h11); expectByte(2, 8'h12); expectByte(3, 8'h13);
      expectByte(0, 8'h10); expectByte(0, 8'h20);
      for (int k = 0; k < 5; k++) begin
         waitTxReq(ok);
         nChecks++;
         if (!ok || expQ.size() == 0) begin
            nFails++; $display("FAIL contention_frame%0d: tx_req=0 after 200 cycles, required a pulse", k);
         end else begin
            e = expQ.pop_front(); oh = '0; oh[e.idx] = 1'b1;
            if (tbIf.tx_data !== e.data || tbIf.req_ready !== oh || tbIf.grant !== oh) begin
               nFails++;
               $display("FAIL contention_frame%0d: tx_data=%h req_ready=%b grant=%b, required %h %b %b",
                        k, tbIf.tx_data, tbIf.req_ready, tbIf.grant, e.data, oh, oh);
            end
         end
         // Ready seen high at cycle R is sampled at R+1; tx_req follows GAP+1 edges later.
         if (ok && k > 0) begin
            nChecks++;
            if (cyc - lastRise != GAP + 2) begin
               nFails++;
               $display("FAIL contention_gap%0d: spacing=%0d cycles, required %0d", k, cyc - lastRise, GAP + 2);
            end
         end
      end
      waitIdle(ok);
   endtask

   task automatic test_lock();
      bit ok; expT e; logic [N-1:0] oh;
      loadByte(2, 8'hB0, 1'b1);
      loadByte(1, 8'hA1, 1'b0); loadByte(1, 8'hA2, 1'b0); loadByte(1, 8'hA3, 1'b1);
      expectByte(1, 8'hA1); expectByte(1, 8'hA2); expectByte(1, 8'hA3); expectByte(2, 8'hB0);
      for (int k = 0; k < 4; k++) begin
         waitTxReq(ok);
         nChecks++;
         if (!ok || expQ.size() == 0) begin
            nFails++; $display("FAIL lock_frame%0d: tx_req=0 after 200 cycles, required a pulse", k);
         end else begin
            e = expQ.pop_front(); oh = '0; oh[e.idx] = 1'b1;
            if (tbIf.tx_data !== e.data || tbIf.req_ready !== oh || tbIf.grant !== oh) begin
               nFails++;
               $display("FAIL lock_frame%0d: tx_data=%h req_ready=%b grant=%b, required %h %b %b",
                        k, tbIf.tx_data, tbIf.req_ready, tbIf.grant, e.data, oh, oh);
            end
         end
         if (ok && k < 2) begin
            repeat (3) @(negedge clk);
            nChecks++;
            if (tbIf.grant !== 4'b0010 || tbIf.busy !== 1'b1) begin
               nFails++;
               $display("FAIL lock_hold%0d: grant=%b busy=%b, required 0010 1", k, tbIf.grant, tbIf.busy);
            end
         end
      end
      waitIdle(ok);
   endtask

   task automatic test_timeout();
      bit ok; expT e; logic [N-1:0] oh;
      int firstAt, pulses, extraReq;
      modelOn = 1'b0; forceReady = 1'b1;
      loadByte(3, 8'hC3, 1'b1);
      expectByte(3, 8'hC3);
      waitTxReq(ok);
      nChecks++;
      if (!ok || expQ.size() == 0) begin
         nFails++; $display("FAIL timeout_frame: tx_req=0 after 200 cycles, required a pulse");
      end else begin
         e = expQ.pop_front(); oh = '0; oh[e.idx] = 1'b1;
         if (tbIf.tx_data !== e.data || tbIf.req_ready !== oh || tbIf.grant !== oh) begin
            nFails++;
            $display("FAIL timeout_frame: tx_data=%h req_ready=%b grant=%b, required %h %b %b",
                     tbIf.tx_data, tbIf.req_ready, tbIf.grant, e.data, oh, oh);
         end
      end
      firstAt = 0; pulses = 0; extraReq = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (tbIf.timeout_err === 1'b1) begin
            if (pulses == 0) firstAt = i;
            pulses++;
         end
         if (tbIf.tx_req === 1'b1) extraReq++;
      end
      // tx_req cycle, then WAIT_LOW entry one edge later, then TMO edges of ready-high.
      nChecks++;
      if (firstAt != TMO + 1) begin
         nFails++; $display("FAIL timeout_latency: pulse at %0d cycles after tx_req, required %0d", firstAt, TMO + 1);
      end
      nChecks++;
      if (pulses != 1) begin
         nFails++; $display("FAIL timeout_pulse_count: %0d cycles high, required 1", pulses);
      end
      nChecks++;
      if (extraReq != 0 || tbIf.busy !== 1'b0 || tbIf.grant !== '0) begin
         nFails++;
         $display("FAIL timeout_release: extra tx_req=%0d busy=%b grant=%b, required 0 0 0000",
                  extraReq, tbIf.busy, tbIf.grant);
      end
      modelOn = 1'b1;
   endtask

   task automatic test_idle_wait();
      bit ok; expT e; logic [N-1:0] oh;
      int reqs;
      modelOn = 1'b0; forceReady = 1'b0;
      repeat (2) @(negedge clk);
      loadByte(0, 8'h77, 1'b1);
      expectByte(0, 8'h77);
      reqs = 0;
      repeat (10) begin
         @(negedge clk);
         if (tbIf.tx_req === 1'b1 || tbIf.req_ready !== '0) reqs++;
      end
      nChecks++;
      if (reqs != 0 || tbIf.busy !== 1'b0) begin
         nFails++; $display("FAIL idle_not_ready: accepts=%0d busy=%b, required 0 0", reqs, tbIf.busy);
      end
      modelOn = 1'b1;
      waitTxReq(ok);
      nChecks++;
      if (!ok || expQ.size() == 0) begin
         nFails++; $display("FAIL idle_ready_frame: tx_req=0 after 200 cycles, required a pulse");
      end else begin
         e = expQ.pop_front(); oh = '0; oh[e.idx] = 1'b1;
         if (tbIf.tx_data !== e.data || tbIf.req_ready !== oh || tbIf.grant !== oh) begin
            nFails++;
            $display("FAIL idle_ready_frame: tx_data=%h req_ready=%b grant=%b, required %h %b %b",
                     tbIf.tx_data, tbIf.req_ready, tbIf.grant, e.data, oh, oh);
         end
      end
      waitIdle(ok);
   endtask

   task automatic test_reset_midframe();
      bit ok; expT e; logic [N-1:0] oh;
      loadByte(1, 8'hD1, 1'b1);
      expectByte(1, 8'hD1);
      waitTxReq(ok);
      nChecks++;
      if (!ok || expQ.size() == 0) begin
         nFails++; $display("FAIL midreset_frame: tx_req=0 after 200 cycles, required a pulse");
      end else begin
         e = expQ.pop_front(); oh = '0; oh[e.idx] = 1'b1;
         if (tbIf.tx_data !== e.data || tbIf.req_ready !== oh || tbIf.grant !== oh) begin
            nFails++;
            $display("FAIL midreset_frame: tx_data=%h req_ready=%b grant=%b, required %h %b %b",
                     tbIf.tx_data, tbIf.req_ready, tbIf.grant, e.data, oh, oh);
         end
      end
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      modelOn = 1'b0; forceReady = 1'b1;
      #1;
      nChecks++;
      if ({tbIf.grant, tbIf.req_ready, tbIf.busy, tbIf.tx_data, tbIf.tx_req, tbIf.timeout_err} !== '0) begin
         nFails++;
         $display("FAIL midreset_async: grant=%b busy=%b tx_data=%h, required 0000 0 00 without a clock edge",
                  tbIf.grant, tbIf.busy, tbIf.tx_data);
      end
      loadByte(2, 8'hE2, 1'b1); loadByte(3, 8'hE3, 1'b1);
      expectByte(2, 8'hE2); expectByte(3, 8'hE3);
      @(negedge clk);
      rst = 1'b1; modelOn = 1'b1;
      for (int k = 0; k < 2; k++) begin
         waitTxReq(ok);
         nChecks++;
         if (!ok || expQ.size() == 0) begin
            nFails++; $display("FAIL midreset_after%0d: tx_req=0 after 200 cycles, required a pulse", k);
         end else begin
            e = expQ.pop_front(); oh = '0; oh[e.idx] = 1'b1;
            if (tbIf.tx_data !== e.data || tbIf.req_ready !== oh || tbIf.grant !== oh) begin
               nFails++;
               $display("FAIL midreset_after%0d: tx_data=%h req_ready=%b grant=%b, required %h %b %b",
                        k, tbIf.tx_data, tbIf.req_ready, tbIf.grant, e.data, oh, oh);
            end
         end
      end
      waitIdle(ok);
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_lock();
      test_timeout();
      test_idle_wait();
      test_reset_midframe();
      nChecks++;
      if (expQ.size() != 0) begin
         nFails++; $display("FAIL scoreboard_drained: %0d bytes never sent, required 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
